// File: rtl/bcd_scan_driver.sv
// rtl/bcd_scan_driver.sv - time-multiplexed BCD digit scanner feeding a BCD-to-7-segment decoder
module bcd_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  lz_blank_en,
    input  logic                  lamp_test,
    output logic [3:0]            D,
    output logic                  LE,
    output logic                  BL,
    output logic                  LT,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(BLANK_CYCLES);

    typedef enum logic [0:0] {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } slot_state_t;

    // With no guard cycles the slot starts directly in SHOW.
    localparam slot_state_t RST_STATE = (BLANK_CYCLES > 0) ? GUARD : SHOW;

    logic [CNT_W-1:0]    cnt, nxt_cnt;
    logic [IDX_W-1:0]    idx, nxt_idx;
    logic [4*DIGITS-1:0] display, nxt_display;
    logic [4*DIGITS-1:0] shadow, nxt_shadow;
    logic                pending, nxt_pending;
    slot_state_t         state, nxt_state;
    logic                frame_end;
    logic                nxt_frame_end;
    logic [DIGITS-1:0]   zero_above;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                lz_hide;

    // Position of the next cycle, load/commit bookkeeping and slot transition.
    // Outputs are registered from these next-cycle values so that the cycle
    // presenting slot (idx, cnt) shows exactly that slot's digit.
    always_comb begin
        frame_end     = (cnt == CNT_MAX) && (idx == IDX_MAX);
        nxt_cnt       = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        nxt_idx       = idx;
        if (cnt == CNT_MAX) begin
            nxt_idx = (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
        end
        nxt_frame_end = (nxt_cnt == CNT_MAX) && (nxt_idx == IDX_MAX);

        nxt_display = display;
        nxt_shadow  = shadow;
        nxt_pending = pending;
        if (frame_end) begin
            // A load landing on the commit cycle goes straight to the display.
            if (load) begin
                nxt_display = bcd_in;
                nxt_pending = 1'b0;
            end else if (pending) begin
                nxt_display = shadow;
                nxt_pending = 1'b0;
            end
        end else if (load) begin
            nxt_shadow  = bcd_in;
            nxt_pending = 1'b1;
        end

        nxt_state = state;
        case (state)
            GUARD:   if (nxt_cnt == CNT_GUARD) nxt_state = SHOW;
            SHOW:    if (BLANK_CYCLES > 0 && nxt_cnt == '0) nxt_state = GUARD;
            default: nxt_state = RST_STATE;
        endcase
    end

    // Leading-zero mask: zero_above[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        zero_above = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (nxt_display[4*i +: 4] == 4'd0);
            zero_above[i] = zero_run;
        end
        cur_nib = nxt_display[{nxt_idx, 2'b00} +: 4];
        lz_hide = lz_blank_en && (nxt_idx != '0) && zero_above[nxt_idx];
    end

    // Scan counters, data registers, slot FSM and registered decoder outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            display    <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            state      <= RST_STATE;
            D          <= 4'd0;
            LE         <= 1'b0;
            BL         <= 1'b0;
            LT         <= 1'b1;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            display    <= nxt_display;
            shadow     <= nxt_shadow;
            pending    <= nxt_pending;
            state      <= nxt_state;
            D          <= cur_nib;
            LE         <= 1'b0;
            LT         <= ~lamp_test;
            frame_done <= nxt_frame_end;
            case (nxt_state)
                SHOW: begin
                    dig_sel <= DIGITS'(1) << nxt_idx;
                    BL      <= lamp_test | ~lz_hide;
                end
                default: begin
                    dig_sel <= '0;
                    BL      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb/tb_bcd_scan_driver.sv - table-driven bench for bcd_scan_driver (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
module tb_bcd_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic        lz_blank_en;
    logic        lamp_test;
    logic [3:0]  D;
    logic        LE;
    logic        BL;
    logic        LT;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int wait_cnt;

    bcd_scan_driver #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .bcd_in      (bcd_in),
        .lz_blank_en (lz_blank_en),
        .lamp_test   (lamp_test),
        .D           (D),
        .LE          (LE),
        .BL          (BL),
        .LT          (LT),
        .dig_sel     (dig_sel),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_chk;
        logic [3:0]  d;
        logic [3:0]  sel;
        logic        bl;
        logic        lt_o;
        logic        fd;
        bit          ld;
        logic [15:0] bcd;
        logic        lz;
        logic        lt;
        bit          rs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t chk(int cyc, logic [3:0] d, logic [3:0] sel, logic bl, logic lt_o, logic fd);
        vec_t v;
        v = '{cyc: cyc, is_chk: 1'b1, d: d, sel: sel, bl: bl, lt_o: lt_o, fd: fd,
              ld: 1'b0, bcd: 16'h0, lz: 1'b0, lt: 1'b0, rs: 1'b0};
        return v;
    endfunction

    function automatic vec_t drv(int cyc, bit ld, logic [15:0] bcd, logic lz, logic lt, bit rs);
        vec_t v;
        v = '{cyc: cyc, is_chk: 1'b0, d: 4'h0, sel: 4'h0, bl: 1'b0, lt_o: 1'b0, fd: 1'b0,
              ld: ld, bcd: bcd, lz: lz, lt: lt, rs: rs};
        return v;
    endfunction

    initial begin
        // Input changes take effect at the clock edge that ends the listed cycle.
        vecs.push_back(drv(3,   1, 16'h1234, 0, 0, 0));
        vecs.push_back(drv(70,  1, 16'h0070, 1, 0, 0));
        vecs.push_back(drv(127, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(drv(160, 1, 16'h0000, 1, 0, 0));
        vecs.push_back(drv(228, 0, 16'h0000, 1, 1, 0));
        vecs.push_back(drv(244, 0, 16'h0000, 1, 0, 0));
        vecs.push_back(drv(250, 1, 16'h1111, 0, 0, 0));
        vecs.push_back(drv(255, 1, 16'h5678, 0, 0, 0));
        vecs.push_back(drv(298, 1, 16'h4321, 0, 0, 0));
        vecs.push_back(drv(360, 1, 16'h9999, 0, 0, 0));
        vecs.push_back(drv(365, 0, 16'h0000, 0, 0, 1));

        // Reset state and first (empty) frame.
        vecs.push_back(chk(0,   4'h0, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(1,   4'h0, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(2,   4'h0, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(30,  4'h0, 4'b1000, 1, 1, 0));
        vecs.push_back(chk(31,  4'h0, 4'b1000, 1, 1, 1));
        // 1234 committed at cycle 31, shown from 32.
        vecs.push_back(chk(32,  4'h4, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(33,  4'h4, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(34,  4'h4, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(39,  4'h4, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(40,  4'h3, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(41,  4'h3, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(42,  4'h3, 4'b0010, 1, 1, 0));
        vecs.push_back(chk(47,  4'h3, 4'b0010, 1, 1, 0));
        vecs.push_back(chk(50,  4'h2, 4'b0100, 1, 1, 0));
        vecs.push_back(chk(58,  4'h1, 4'b1000, 1, 1, 0));
        vecs.push_back(chk(63,  4'h1, 4'b1000, 1, 1, 1));
        vecs.push_back(chk(64,  4'h4, 4'b0000, 0, 1, 0));
        // 0070 with leading-zero blanking, then without.
        vecs.push_back(chk(98,  4'h0, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(106, 4'h7, 4'b0010, 1, 1, 0));
        vecs.push_back(chk(114, 4'h0, 4'b0100, 0, 1, 0));
        vecs.push_back(chk(122, 4'h0, 4'b1000, 0, 1, 0));
        vecs.push_back(chk(127, 4'h0, 4'b1000, 0, 1, 1));
        vecs.push_back(chk(130, 4'h0, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(138, 4'h7, 4'b0010, 1, 1, 0));
        vecs.push_back(chk(146, 4'h0, 4'b0100, 1, 1, 0));
        vecs.push_back(chk(154, 4'h0, 4'b1000, 1, 1, 0));
        // All-zero value: only digit 0 lit.
        vecs.push_back(chk(194, 4'h0, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(202, 4'h0, 4'b0010, 0, 1, 0));
        vecs.push_back(chk(210, 4'h0, 4'b0100, 0, 1, 0));
        vecs.push_back(chk(218, 4'h0, 4'b1000, 0, 1, 0));
        // Lamp test mid-frame.
        vecs.push_back(chk(228, 4'h0, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(229, 4'h0, 4'b0001, 1, 0, 0));
        vecs.push_back(chk(232, 4'h0, 4'b0000, 0, 0, 0));
        vecs.push_back(chk(234, 4'h0, 4'b0010, 1, 0, 0));
        vecs.push_back(chk(242, 4'h0, 4'b0100, 1, 0, 0));
        vecs.push_back(chk(244, 4'h0, 4'b0100, 1, 0, 0));
        vecs.push_back(chk(245, 4'h0, 4'b0100, 0, 1, 0));
        // Load on the commit cycle overrides the pending shadow.
        vecs.push_back(chk(258, 4'h8, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(266, 4'h7, 4'b0010, 1, 1, 0));
        vecs.push_back(chk(274, 4'h6, 4'b0100, 1, 1, 0));
        vecs.push_back(chk(282, 4'h5, 4'b1000, 1, 1, 0));
        vecs.push_back(chk(287, 4'h5, 4'b1000, 1, 1, 1));
        vecs.push_back(chk(290, 4'h8, 4'b0001, 1, 1, 0));
        // Mid-frame load waits for the frame boundary.
        vecs.push_back(chk(306, 4'h6, 4'b0100, 1, 1, 0));
        vecs.push_back(chk(314, 4'h5, 4'b1000, 1, 1, 0));
        vecs.push_back(chk(319, 4'h5, 4'b1000, 1, 1, 1));
        vecs.push_back(chk(322, 4'h1, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(330, 4'h2, 4'b0010, 1, 1, 0));
        // Mid-frame reset discards display and the pending load.
        vecs.push_back(chk(364, 4'h2, 4'b0010, 1, 1, 0));
        vecs.push_back(chk(365, 4'h2, 4'b0010, 1, 1, 0));
        vecs.push_back(chk(366, 4'h0, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(367, 4'h0, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(368, 4'h0, 4'b0001, 1, 1, 0));
        vecs.push_back(chk(376, 4'h0, 4'b0010, 1, 1, 0));
        vecs.push_back(chk(397, 4'h0, 4'b1000, 1, 1, 1));
        vecs.push_back(chk(398, 4'h0, 4'b0000, 0, 1, 0));
        vecs.push_back(chk(400, 4'h0, 4'b0001, 1, 1, 0));

        rst         = 1'b1;
        load        = 1'b0;
        bcd_in      = 16'h0;
        lz_blank_en = 1'b0;
        lamp_test   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        total++;
        if (D !== 4'h0 || dig_sel !== 4'b0000 || BL !== 1'b0 || LT !== 1'b1 ||
            LE !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset: got D=%h sel=%b BL=%b LT=%b fd=%b LE=%b, want D=0 sel=0000 BL=0 LT=1 fd=0 LE=0",
                     D, dig_sel, BL, LT, frame_done, LE);
        end

        rst = 1'b0;

        for (int n = 0; n <= 410; n++) begin
            load = 1'b0;
            rst  = 1'b0;
            foreach (vecs[k]) begin
                if (vecs[k].cyc == n && vecs[k].is_chk) begin
                    total++;
                    if (D !== vecs[k].d || dig_sel !== vecs[k].sel || BL !== vecs[k].bl ||
                        LT !== vecs[k].lt_o || frame_done !== vecs[k].fd || LE !== 1'b0) begin
                        bad++;
                        $display("FAIL cyc%0d: got D=%h sel=%b BL=%b LT=%b fd=%b LE=%b, want D=%h sel=%b BL=%b LT=%b fd=%b LE=0",
                                 n, D, dig_sel, BL, LT, frame_done, LE,
                                 vecs[k].d, vecs[k].sel, vecs[k].bl, vecs[k].lt_o, vecs[k].fd);
                    end
                end
            end
            foreach (vecs[k]) begin
                if (vecs[k].cyc == n && !vecs[k].is_chk) begin
                    load        = vecs[k].ld;
                    bcd_in      = vecs[k].bcd;
                    lz_blank_en = vecs[k].lz;
                    lamp_test   = vecs[k].lt;
                    rst         = vecs[k].rs;
                end
            end
            @(posedge clk);
            #1;
        end

        load     = 1'b0;
        rst      = 1'b0;
        wait_cnt = 0;
        while (frame_done !== 1'b1 && wait_cnt < 40) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL timeout: no frame_done within %0d cycles", wait_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Multiplexed-display front end that sits directly upstream of the BCD-to-7-segment decoder.
- Holds a DIGITS-wide packed BCD word and time-multiplexes it one digit at a time onto the decoder's D[3:0] and LE/BL/LT controls.
- Drives the one-hot digit-select lines, blanks between slots to suppress ghosting, and optionally blanks leading zeros.
- New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGITS, 4, number of multiplexed digits (>=2)
PRESCALE, 50000, clock cycles per digit slot (> BLANK_CYCLES)
BLANK_CYCLES, 2, guard cycles at the start of each slot with display dark (0 = no guard)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
load  input  1  single-cycle strobe: capture bcd_in
bcd_in  input  4*DIGITS  packed BCD; nibble i = digit i, nibble 0 = least significant
lz_blank_en  input  1  1 = blank leading zeros
lamp_test  input  1  1 = force all segments on
D  output  4  digit code to decoder
LE  output  1  decoder latch enable, active high
BL  output  1  decoder blanking, active low
LT  output  1  decoder lamp test, active low
dig_sel  output  DIGITS  one-hot digit enable, active high
frame_done  output  1  one-cycle pulse in the last cycle of each frame

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - Outputs: D=0, LE=0, BL=0, LT=1, dig_sel=0, frame_done=0.
  - Internal state: display reg=0, shadow reg=0, pending=0, slot index=0, prescale count=0.
- Reset mid-frame: same reset values apply; any pending load is discarded.
- Counters:
  - cnt runs 0..PRESCALE-1, then wraps to 0.
  - idx increments on each cnt wrap and runs 0..DIGITS-1, then wraps to 0.
  - Cycle n after rst deasserts (n=0 is the first cycle) presents idx = (n/PRESCALE) mod DIGITS and cnt = n mod PRESCALE on the outputs.
- Slot FSM states:
  - GUARD (cnt < BLANK_CYCLES): dig_sel=0, BL=0, D = display nibble idx.
  - SHOW (cnt >= BLANK_CYCLES): dig_sel = one-hot(idx), D = display nibble idx, BL per the blanking rule below.
  - GUARD -> SHOW when cnt reaches BLANK_CYCLES.
  - SHOW -> GUARD when cnt wraps.
  - BLANK_CYCLES = 0: GUARD is never entered.
- LE is held at 0 at all times (decoder transparent).
- Leading-zero blanking, when lz_blank_en=1:
  - Digit i is blanked (BL=0 during SHOW) iff i > 0 and every display nibble j >= i equals 0.
  - Digit 0 is never blanked.
  - With lz_blank_en=0, BL=1 throughout SHOW.
- Nibbles > 9 are forwarded unchanged; the decoder dark-codes them.
- Lamp test:
  - lamp_test=1 gives LT=0 and BL=1 in SHOW, taking effect on the next output cycle; this overrides leading-zero blanking.
  - GUARD still forces dig_sel=0 while lamp test is active.
  - Scanning continues normally.
- Load/commit:
  - load=1 captures bcd_in into the shadow reg and sets pending.
  - A later load before commit overwrites the shadow.
  - Commit edge is the frame_done cycle (idx=DIGITS-1, cnt=PRESCALE-1). On it, if pending, display <= shadow and pending <= 0.
  - load=1 on the commit cycle bypasses the shadow: display <= bcd_in, pending <= 0.
  - A committed value is first visible at idx=0, cnt=0 of the next frame.
- frame_done is high exactly one cycle per frame, every DIGITS*PRESCALE cycles.

Test Plan:
Use DIGITS=4, PRESCALE=8, BLANK_CYCLES=2; frame = 32 cycles.
1. Release rst, load bcd_in=16'h1234 at cycle 3:
   - frame_done pulses at cycle 31, 63, ...
   - Cycles 32-63 show: D=4 with dig_sel=0001 at cycles 34-39; D=3 with 0010 at cycles 42-47; D=2 with 0100; D=1 with 1000.
   - At cycles 32-33 and 40-41: dig_sel=0, BL=0.
2. load 16'h0070 with lz_blank_en=1:
   - Digits 3 and 2 show BL=0 throughout SHOW.
   - Digit 1 shows D=7, BL=1; digit 0 shows D=0, BL=1.
   - Set lz_blank_en=0: all four digits show BL=1 in SHOW.
3. load 16'h0000 with lz_blank_en=1: only digit 0 is lit (D=0, BL=1); digits 1-3 have BL=0 in SHOW.
4. Assert lamp_test mid-frame:
   - From the next cycle, LT=0 and BL=1 in SHOW; dig_sel keeps scanning; GUARD keeps dig_sel=0.
   - Deassert lamp_test: LT=1 restored on the next cycle.
5. load 16'h5678 on a frame_done cycle while a previous shadow 16'h1111 is pending: the next frame shows 8,7,6,5 and pending=0.
   - Also pulse load at cycle 10 of a frame: digits are unchanged until the frame after the next frame_done.
6. Assert rst at cycle 45 for one cycle: the next cycle has all outputs at their reset values, the display shows 0, and scanning restarts at idx=0, cnt=0.
